// File: rtl/decision_feeder.sv
// Collects three streamed feature words, then drives a decision engine through a
// clear/run sequence and holds its result (or a timeout marker) until consumed.
module decision_feeder #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] feat_i,
  input  logic             feat_valid_i,
  output logic             feat_ready_o,
  output logic [WIDTH-1:0] x1_o,
  output logic [WIDTH-1:0] x2_o,
  output logic [WIDTH-1:0] x3_o,
  output logic             dec_rst_o,
  output logic             start_o,
  input  logic [WIDTH-1:0] y_i,
  input  logic             y_valid_i,
  output logic [WIDTH-1:0] res_o,
  output logic             res_err_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [15:0]      sample_cnt_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {COLLECT, CLEAR, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;
  logic             start_q, start_d;
  logic             dec_rst_q, dec_rst_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             feat_xfer;

  assign feat_xfer = feat_valid_i && (state_q == COLLECT);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    x3_d      = x3_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    unique case (state_q)
      COLLECT: begin
        if (feat_xfer) begin
          unique case (slot_q)
            2'd0:    x1_d = feat_i;
            2'd1:    x2_d = feat_i;
            default: x3_d = feat_i;
          endcase
          if (slot_q == 2'd2) begin
            slot_d  = 2'd0;
            state_d = CLEAR;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        // A real result on the last allowed cycle beats the timeout.
        if (y_valid_i) begin
          res_d     = y_i;
          res_err_d = 1'b0;
          state_d   = DONE;
        end else if (tmo_q == TLAST) begin
          res_d     = '1;
          res_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    // Engine controls are registered copies of the next-state decode.
    dec_rst_d   = (state_d == CLEAR);
    start_d     = (state_d == RUN);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      slot_q      <= 2'd0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      res_q       <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      start_q     <= 1'b0;
      dec_rst_q   <= 1'b0;
      cnt_q       <= 16'd0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      start_q     <= start_d;
      dec_rst_q   <= dec_rst_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  // Ready is qualified by reset so it stays low while reset is held.
  assign feat_ready_o = (state_q == COLLECT) && reset;
  assign x1_o         = x1_q;
  assign x2_o         = x2_q;
  assign x3_o         = x3_q;
  assign dec_rst_o    = dec_rst_q;
  assign start_o      = start_q;
  assign res_o        = res_q;
  assign res_err_o    = res_err_q;
  assign res_valid_o  = res_valid_q;
  assign sample_cnt_o = cnt_q;

endmodule
